// File: rtl/dmem_mmio_responder.sv
// ============================================================================
// dmem_mmio_responder : data-memory responder (RAM + timer/status/TX-FIFO MMIO)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_mmio_responder #(
  parameter int          RAM_DEPTH  = 4096,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_F000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int          RAM_AW    = $clog2(RAM_DEPTH);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] RAM_LIMIT = 32'(RAM_DEPTH);
  localparam logic [CW-1:0] FIFO_FULL_COUNT = CW'(FIFO_DEPTH);

  // Storage and peripheral state
  logic [31:0]    ram [RAM_DEPTH];
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [31:0]    r_timer;
  logic [31:0]    r_cmp;
  logic           r_irq;
  logic           r_ovf;

  // Decode
  logic           w_sel_ram;
  logic           w_sel_timer;
  logic           w_sel_cmp;
  logic           w_sel_status;
  logic           w_sel_tx;
  logic           w_wr;
  logic           w_tx_empty;
  logic           w_tx_full;
  logic           w_pop;
  logic           w_push;
  logic           w_push_ok;
  logic           w_push_drop;
  logic           w_match;
  logic [31:0]    w_rd_data;

  assign w_sel_ram    = (address_dmem < RAM_LIMIT);
  assign w_sel_timer  = (address_dmem == MMIO_BASE);
  assign w_sel_cmp    = (address_dmem == MMIO_BASE + 32'd1);
  assign w_sel_status = (address_dmem == MMIO_BASE + 32'd2);
  assign w_sel_tx     = (address_dmem == MMIO_BASE + 32'd3);
  assign w_wr         = wren & ~reset;

  assign w_tx_empty   = (r_count == '0);
  assign w_tx_full    = (r_count == FIFO_FULL_COUNT);
  assign w_pop        = ~w_tx_empty & tx_ready;
  assign w_push       = w_wr & w_sel_tx;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_push_ok    = w_push & (~w_tx_full | w_pop);
  assign w_push_drop  = w_push & ~w_push_ok;
  assign w_match      = (r_timer == r_cmp);

  assign tx_valid = ~w_tx_empty;
  assign tx_data  = w_tx_empty ? 8'h00 : fifo_mem[r_rd_ptr];
  assign irq      = r_irq;

  // Read mux sees pre-update state, giving read-before-write everywhere
  always_comb begin
    w_rd_data = 32'h0;
    if (w_sel_ram)
      w_rd_data = ram[address_dmem[RAM_AW-1:0]];
    else if (w_sel_timer)
      w_rd_data = r_timer;
    else if (w_sel_cmp)
      w_rd_data = r_cmp;
    else if (w_sel_status)
      w_rd_data = {28'h0, r_ovf, w_tx_full, w_tx_empty, r_irq};
    else if (w_sel_tx)
      w_rd_data = {{(32-CW){1'b0}}, r_count};
  end

  always_ff @(posedge clock) begin
    if (reset)
      q_dmem <= 32'h0;
    else
      q_dmem <= w_rd_data;
  end

  // RAM contents survive reset
  always_ff @(posedge clock) begin
    if (w_wr & w_sel_ram)
      ram[address_dmem[RAM_AW-1:0]] <= data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer <= 32'h0;
      r_cmp   <= 32'h0;
    end else begin
      r_timer <= (wren & w_sel_timer) ? data : r_timer + 32'd1;
      if (wren & w_sel_cmp)
        r_cmp <= data;
    end
  end

  // Set beats clear for both sticky flags
  always_ff @(posedge clock) begin
    if (reset) begin
      r_irq <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_match)
        r_irq <= 1'b1;
      else if (wren & w_sel_status & data[0])
        r_irq <= 1'b0;
      if (w_push_drop)
        r_ovf <= 1'b1;
      else if (wren & w_sel_status & data[1])
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok)
      fifo_mem[r_wr_ptr] <= data[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
// ============================================================================
// tb_dmem_mmio_responder : directed + randomized check against a queue model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_mmio_responder;

  localparam int          RAM_DEPTH  = 4096;
  localparam logic [31:0] MMIO_BASE  = 32'h0000_F000;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [31:0] A_TIMER  = MMIO_BASE;
  localparam logic [31:0] A_CMP    = MMIO_BASE + 32'd1;
  localparam logic [31:0] A_STATUS = MMIO_BASE + 32'd2;
  localparam logic [31:0] A_TX     = MMIO_BASE + 32'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = 32'h0;
  logic [31:0] data = 32'h0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  dmem_mmio_responder #(
    .RAM_DEPTH (RAM_DEPTH),
    .MMIO_BASE (MMIO_BASE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address_dmem(address_dmem),
    .data        (data),
    .wren        (wren),
    .q_dmem      (q_dmem),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .irq         (irq)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [7:0]  m_fifo [$];
  logic [31:0] m_timer = 0;
  logic [31:0] m_cmp = 0;
  logic        m_irq = 0;
  logic        m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock of the documented behaviour; returns what q_dmem must show after the edge
  task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic we,
                            input logic rdy, input logic rst, output logic [31:0] q);
    int  sz;
    bit  popped;
    if (rst) begin
      q = 0; m_timer = 0; m_cmp = 0; m_irq = 0; m_ovf = 0;
      m_fifo.delete();
      return;
    end
    sz = m_fifo.size();
    if (a < RAM_DEPTH)      q = m_ram.exists(int'(a)) ? m_ram[int'(a)] : 32'h0;
    else if (a == A_TIMER)  q = m_timer;
    else if (a == A_CMP)    q = m_cmp;
    else if (a == A_STATUS) q = {28'h0, m_ovf, sz == FIFO_DEPTH, sz == 0, m_irq};
    else if (a == A_TX)     q = sz;
    else                    q = 0;
    if (we && a == A_STATUS && d[0]) m_irq = 0;
    if (m_timer == m_cmp)            m_irq = 1;
    if (we && a == A_STATUS && d[1]) m_ovf = 0;
    if (we && a < RAM_DEPTH) m_ram[int'(a)] = d;
    m_timer = (we && a == A_TIMER) ? d : m_timer + 1;
    if (we && a == A_CMP) m_cmp = d;
    popped = (sz > 0) && rdy;
    if (popped) void'(m_fifo.pop_front());
    if (we && a == A_TX) begin
      if (sz < FIFO_DEPTH || popped) m_fifo.push_back(d[7:0]);
      else                           m_ovf = 1;
    end
  endtask

  logic [31:0] last_q;

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we,
                     input logic rdy, input logic rst);
    logic [31:0] e;
    address_dmem = a; data = d; wren = we; tx_ready = rdy; reset = rst;
    model_step(a, d, we, rdy, rst, e);
    @(posedge clock);
    #1;
    last_q = q_dmem;
    chk("q_dmem", q_dmem, e);
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
    chk("tx_valid", {31'h0, tx_valid}, {31'h0, m_fifo.size() != 0});
    chk("tx_data", {24'h0, tx_data}, {24'h0, (m_fifo.size() != 0) ? m_fifo[0] : 8'h00});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(a, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(a, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] ra;
    int pick;

    cyc(0, 0, 0, 0, 1);
    cyc(A_TIMER, 32'h55, 1, 0, 1);
    chk("reset_q", q_dmem, 32'h0);
    chk("reset_txv", {31'h0, tx_valid}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    wr(A_STATUS, 32'h1);
    for (int i = 0; i < 32; i++) wr(i, (i == 9) ? 32'h0 : $urandom);

    // RAM path
    wr(5, 32'hDEADBEEF);
    rd(5);                           chk("ram_rd5", last_q, 32'hDEADBEEF);
    rd(RAM_DEPTH + 7);               chk("ram_oob", last_q, 32'h0);
    wr(9, 32'h1234);                 chk("ram_rbw_old", last_q, 32'h0);
    rd(9);                           chk("ram_rbw_new", last_q, 32'h1234);
    wr(A_STATUS, 32'h1);

    // FIFO fill and overflow
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h10 + i);
    rd(A_TX);                        chk("fifo_count8", last_q, 32'd8);
    rd(A_STATUS);                    chk("status_full", last_q, 32'b0100);
    wr(A_TX, 32'h18);
    rd(A_STATUS);                    chk("status_ovf", last_q, 32'b1100);
    chk("fifo_head", {24'h0, tx_data}, 32'h10);
    wr(A_STATUS, 32'h2);
    rd(A_STATUS);                    chk("ovf_clear", last_q, 32'b0100);

    // Drain
    for (int i = 0; i < 8; i++) begin
      chk("drain_byte", {24'h0, tx_data}, 32'h10 + i);
      cyc(0, 0, 0, 1, 0);
    end
    chk("drain_empty", {31'h0, tx_valid}, 32'h0);
    rd(A_TX);                        chk("drain_count0", last_q, 32'd0);
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h20 + i);
    cyc(A_TX, 32'h28, 1, 1, 0);
    rd(A_TX);                        chk("full_pushpop_cnt", last_q, 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("pushpop_byte", {24'h0, tx_data}, 32'h21 + i);
      cyc(0, 0, 0, 1, 0);
    end
    wr(A_STATUS, 32'h3);

    // Timer and compare
    wr(A_CMP, 32'd103);
    wr(A_TIMER, 32'd100);
    rd(A_TIMER);                     chk("timer_load", last_q, 32'd100);
    rd(0); rd(0);                    chk("irq_before", {31'h0, irq}, 32'h0);
    rd(0);                           chk("irq_rise", {31'h0, irq}, 32'h1);
    wr(A_STATUS, 32'h1);             chk("irq_clear", {31'h0, irq}, 32'h0);
    wr(A_TIMER, 32'd500);
    wr(A_CMP, 32'd502);
    rd(0);
    wr(A_STATUS, 32'h1);             chk("irq_set_wins", {31'h0, irq}, 32'h1);
    wr(A_STATUS, 32'h1);
    wr(A_TIMER, 32'hFFFF_FFFE);
    rd(0);
    rd(A_TIMER);                     chk("timer_max", last_q, 32'hFFFF_FFFF);
    rd(A_TIMER);                     chk("timer_wrap", last_q, 32'h0);

    // Reset mid-operation
    wr(20, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) wr(A_TX, 32'hA0 + i);
    wr(A_CMP, 32'h202);
    wr(A_TIMER, 32'h200);
    rd(A_STATUS); rd(0); rd(0);      chk("pre_reset_irq", {31'h0, irq}, 32'h1);
    cyc(A_TIMER, 32'h77, 1, 0, 1);
    chk("rst_txv", {31'h0, tx_valid}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_q", q_dmem, 32'h0);
    rd(A_TIMER);                     chk("rst_timer", last_q, 32'h0);
    rd(A_CMP);                       chk("rst_cmp", last_q, 32'h0);
    rd(20);                          chk("rst_ram_kept", last_q, 32'hCAFEF00D);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      pick = $urandom_range(0, 9);
      if (pick < 4)      ra = $urandom_range(0, 31);
      else if (pick < 9) ra = MMIO_BASE + 32'(pick - 4);
      else               ra = ($urandom_range(0, 1) != 0) ? 32'(RAM_DEPTH + $urandom_range(0, 1000)) : 32'hFFFF_FFF0;
      cyc(ra, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
